// File: rtl/fir_systolic_cfg.sv
// Configurable transposed-form (systolic) FIR filter.
// Each tap multiplies the incoming sample by its coefficient and adds the
// partial sum from the next stage. The whole chain stalls when in_valid is 0.
// The output is rounded half-up, shifted, saturated and registered.
// Coefficients are held in a small register file that can be written on
// any cycle. A coefficient that is rewritten only affects samples accepted
// after the write.
module fir_systolic_cfg #(
    parameter int NTAP   = 8,
    parameter int DSIZE  = 16,
    parameter int CSIZE  = 16,
    parameter int OSHIFT = 0,
    parameter int OWIDTH = 2 * DSIZE,
    parameter int WARMUP = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [DSIZE-1:0]    in_data,
    input  logic                       coef_wr,
    input  logic [$clog2(NTAP)-1:0]    coef_addr,
    input  logic signed [CSIZE-1:0]    coef_data,
    output logic                       out_valid,
    output logic signed [OWIDTH-1:0]   out_data,
    output logic                       out_ovf
);

    localparam int AW   = $clog2(NTAP);
    localparam int ACCW = DSIZE + CSIZE + $clog2(NTAP);
    // Working width leaves headroom for the rounding add and the saturation limits.
    localparam int WW   = ((ACCW + 1 > OWIDTH) ? ACCW + 1 : OWIDTH) + 1;
    localparam int RSH  = (OSHIFT > 0) ? OSHIFT - 1 : 0;
    localparam logic signed [WW-1:0] RND     = (OSHIFT > 0) ? (WW'(1) << RSH) : '0;
    localparam logic signed [WW-1:0] SAT_MAX = (WW'(1) << (OWIDTH - 1)) - WW'(1);
    localparam logic signed [WW-1:0] SAT_MIN = -(WW'(1) << (OWIDTH - 1));

    logic signed [CSIZE-1:0]  coef_q [NTAP];
    logic signed [CSIZE-1:0]  coef_d [NTAP];
    logic signed [ACCW-1:0]   psum_q [NTAP-1];
    logic signed [ACCW-1:0]   psum_d [NTAP-1];
    logic signed [ACCW-1:0]   prod   [NTAP];
    logic signed [ACCW-1:0]   acc;
    logic signed [WW-1:0]     acc_w;
    logic signed [WW-1:0]     shf_w;
    logic signed [OWIDTH-1:0] sat_data;
    logic                     sat_ovf;
    logic [AW-1:0]            fill_q, fill_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [OWIDTH-1:0] out_data_q, out_data_d;
    logic                     out_ovf_q, out_ovf_d;

    // Coefficient writes and per-tap products. The products use the
    // coefficients from before any write in the same cycle.
    always_comb begin
        for (int k = 0; k < NTAP; k++) begin
            coef_d[k] = coef_q[k];
            if (coef_wr && (coef_addr == AW'(k))) begin
                coef_d[k] = coef_data;
            end
            prod[k] = ACCW'(in_data) * ACCW'(coef_q[k]);
        end
    end

    // Partial sums flow toward tap 0. The chain only moves on accepted samples.
    always_comb begin
        psum_d = psum_q;
        if (in_valid) begin
            for (int j = 0; j < NTAP - 2; j++) begin
                psum_d[j] = prod[j+1] + psum_q[j+1];
            end
            psum_d[NTAP-2] = prod[NTAP-1];
        end
    end

    // Final accumulate, then round half-up, arithmetic shift and saturate.
    always_comb begin
        acc      = prod[0] + psum_q[0];
        acc_w    = WW'(acc);
        shf_w    = (acc_w + RND) >>> OSHIFT;
        sat_data = OWIDTH'(shf_w);
        sat_ovf  = 1'b0;
        if (shf_w > SAT_MAX) begin
            sat_data = OWIDTH'(SAT_MAX);
            sat_ovf  = 1'b1;
        end else if (shf_w < SAT_MIN) begin
            sat_data = OWIDTH'(SAT_MIN);
            sat_ovf  = 1'b1;
        end
    end

    // Warm-up fill counter and output register update. Data is held while not valid.
    always_comb begin
        fill_d      = fill_q;
        out_valid_d = in_valid && ((WARMUP == 0) || (fill_q == AW'(NTAP - 1)));
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (in_valid && (fill_q != AW'(NTAP - 1))) begin
            fill_d = fill_q + AW'(1);
        end
        if (out_valid_d) begin
            out_data_d = sat_data;
            out_ovf_d  = sat_ovf;
        end
    end

    // State registers. Reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAP; k++) coef_q[k] <= '0;
            for (int j = 0; j < NTAP - 1; j++) psum_q[j] <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            for (int k = 0; k < NTAP; k++) coef_q[k] <= coef_d[k];
            for (int j = 0; j < NTAP - 1; j++) psum_q[j] <= psum_d[j];
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fir_systolic_cfg.sv
// Directed bench for fir_systolic_cfg with a scoreboard queue. Three
// instances cover three configurations: plain (no warm-up), warm-up
// enabled, and narrow shifted output on 5 taps. One instance is active per
// phase, and reset is shared by all three.
module tb_fir_systolic_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [2:0]         iv;
    logic [2:0]         cw;
    logic signed [15:0] in_data;
    logic signed [15:0] coef_data;
    logic [2:0]         coef_addr;

    logic               ov_a, of_a, ov_b, of_b, ov_c, of_c;
    logic signed [31:0] od_a, od_b;
    logic signed [7:0]  od_c;

    fir_systolic_cfg #(.NTAP(8), .WARMUP(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(in_data),
        .coef_wr(cw[0]), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov_a), .out_data(od_a), .out_ovf(of_a));

    fir_systolic_cfg #(.NTAP(8), .WARMUP(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(in_data),
        .coef_wr(cw[1]), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov_b), .out_data(od_b), .out_ovf(of_b));

    fir_systolic_cfg #(.NTAP(5), .OSHIFT(4), .OWIDTH(8), .WARMUP(0)) u_c (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_data(in_data),
        .coef_wr(cw[2]), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov_c), .out_data(od_c), .out_ovf(of_c));

    typedef struct {
        longint y;
        bit     ovf;
    } exp_t;

    exp_t   sbq[$];
    int     checks = 0;
    int     errors = 0;

    int     sel, m_ntap, m_oshift, m_owidth, m_warm, fill;
    longint h_cur[8];
    longint xh[8];
    longint hh[8][8];
    longint last_y;
    bit     last_ovf;
    longint H[8] = '{7, 14, -138, 129, 129, -138, 14, 7};

    task automatic select_dut(input int s, input int ntap, input int osh, input int ow, input int warm);
        sel = s; m_ntap = ntap; m_oshift = osh; m_owidth = ow; m_warm = warm;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            h_cur[i] = 0;
            xh[i] = 0;
            for (int k = 0; k < 8; k++) hh[i][k] = 0;
        end
        fill = 0; last_y = 0; last_ovf = 0;
        sbq.delete();
    endtask

    task automatic step(input bit v, input longint x, input bit w, input int a, input longint d, input bit r);
        bit                exp_v;
        exp_t              e;
        longint            acc, maxv, minv;
        logic              obs_v, obs_o;
        logic signed [63:0] obs_y;
        rst = r; iv = '0; cw = '0;
        iv[sel] = v; cw[sel] = w;
        in_data = 16'(x); coef_addr = 3'(a); coef_data = 16'(d);
        exp_v = 1'b0;
        if (r) begin
            model_reset();
        end else begin
            if (v) begin
                for (int i = 7; i > 0; i--) begin
                    xh[i] = xh[i-1];
                    for (int k = 0; k < 8; k++) hh[i][k] = hh[i-1][k];
                end
                xh[0] = x;
                for (int k = 0; k < 8; k++) hh[0][k] = h_cur[k];
                acc = 0;
                for (int k = 0; k < m_ntap; k++) acc += hh[k][k] * xh[k];
                if (m_oshift > 0) acc += longint'(1) <<< (m_oshift - 1);
                acc = acc >>> m_oshift;
                maxv = (longint'(1) <<< (m_owidth - 1)) - 1;
                minv = -maxv - 1;
                e.ovf = 1'b0;
                e.y = acc;
                if (acc > maxv) begin e.y = maxv; e.ovf = 1'b1; end
                if (acc < minv) begin e.y = minv; e.ovf = 1'b1; end
                exp_v = (m_warm == 0) || (fill == m_ntap - 1);
                if (fill < m_ntap - 1) fill++;
                if (exp_v) begin
                    sbq.push_back(e);
                    last_y = e.y;
                    last_ovf = e.ovf;
                end
            end
            if (w && a < m_ntap) h_cur[a] = d;
        end
        @(posedge clk);
        @(negedge clk);
        case (sel)
            0: begin obs_v = ov_a; obs_y = 64'(od_a); obs_o = of_a; end
            1: begin obs_v = ov_b; obs_y = 64'(od_b); obs_o = of_b; end
            default: begin obs_v = ov_c; obs_y = 64'(od_c); obs_o = of_c; end
        endcase
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL out_valid dut%0d: observed %b expected %b", sel, obs_v, exp_v);
        end
        if (obs_v === 1'b1) begin
            checks++;
            assert (sbq.size() != 0) else begin
                errors++;
                $error("FAIL scoreboard dut%0d: observed unexpected output %0d expected none", sel, obs_y);
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                checks++;
                assert (obs_y === 64'(e.y)) else begin
                    errors++;
                    $error("FAIL out_data dut%0d: observed %0d expected %0d", sel, obs_y, e.y);
                end
                checks++;
                assert (obs_o === e.ovf) else begin
                    errors++;
                    $error("FAIL out_ovf dut%0d: observed %b expected %b", sel, obs_o, e.ovf);
                end
            end
        end else begin
            checks++;
            assert (obs_y === 64'(last_y)) else begin
                errors++;
                $error("FAIL hold_data dut%0d: observed %0d expected %0d", sel, obs_y, last_y);
            end
            checks++;
            assert (obs_o === last_ovf) else begin
                errors++;
                $error("FAIL hold_ovf dut%0d: observed %b expected %b", sel, obs_o, last_ovf);
            end
        end
    endtask

    initial begin
        rst = 1'b0; iv = '0; cw = '0; in_data = '0; coef_addr = '0; coef_data = '0;

        // Plain 8-tap configuration: impulse response.
        select_dut(0, 8, 0, 32, 0);
        step(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) step(0, 0, 1, k, H[k], 0);
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);

        // Toggled in_valid: outputs appear only on valid cycles, held in between.
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 0, 0, 0);
            step(0, 77, 0, 0, 0, 0);
        end

        // A coefficient write coincident with sample 3 only affects later samples.
        step(1, 10, 0, 0, 0, 0);
        step(1, 20, 0, 0, 0, 0);
        step(1, 30, 1, 0, 5, 0);
        step(1, 40, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);

        // Random samples with occasional h[0] rewrites and stalls.
        for (int i = 0; i < 24; i++) begin
            step(1'($urandom_range(0, 1)), longint'($urandom_range(0, 4000)) - 2000,
                 1'($urandom_range(0, 3) == 0), 0, longint'($urandom_range(0, 400)) - 200, 0);
        end

        // Reset mid-stream with a coincident write: history and coefficients cleared.
        step(1, 55, 1, 2, 99, 1);
        for (int i = 0; i < 3; i++) step(1, 123, 0, 0, 0, 0);
        step(0, 0, 1, 0, 3, 0);
        step(1, 10, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Warm-up configuration: constant input 100.
        select_dut(1, 8, 0, 32, 1);
        step(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) step(0, 0, 1, k, H[k], 0);
        for (int i = 0; i < 4; i++) step(1, 100, 0, 0, 0, 0);
        step(0, 100, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 100, 0, 0, 0, 0);

        // Narrow shifted output on 5 taps: rounding, saturation, ignored addresses.
        select_dut(2, 5, 4, 8, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 127, 0);
        step(0, 0, 1, 5, 99, 0);
        step(0, 0, 1, 7, -50, 0);
        step(1, 32767, 0, 0, 0, 0);
        step(1, 24, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, -32768, 0, 0, 0, 0);
        step(1, -1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
